// File: rtl/pe_strided_multifilter.sv
// Row-stationary 1D-convolution PE: F interleaved filters, run-time stride, one MAC per cycle,
// then a valid/ready drain that adds the neighbour's psum. Define PE_SAT_EN for saturating arithmetic.
module pe_strided_multifilter #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int W_DEPTH  = 16,
    parameter int A_DEPTH  = 16,
    parameter int S_DEPTH  = 16,
    parameter int MAX_FILT = 4
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [7:0]                  cfg_wcount,
    input  logic [7:0]                  cfg_acount,
    input  logic [3:0]                  cfg_stride,
    input  logic [$clog2(MAX_FILT):0]   cfg_nfilt,
    input  logic                        w_valid_i,
    input  logic [DATA_W-1:0]           w_data_i,
    input  logic                        a_valid_i,
    input  logic [DATA_W-1:0]           a_data_i,
    input  logic                        start_i,
    input  logic                        drain_i,
    input  logic [ACC_W-1:0]            psum_i,
    input  logic                        psum_valid_i,
    output logic                        psum_ready_o,
    output logic [ACC_W-1:0]            psum_o,
    output logic                        psum_valid_o,
    input  logic                        psum_ready_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        drain_done_o,
    output logic                        cfg_err_o
);
    localparam int FW  = $clog2(MAX_FILT) + 1;
    localparam int WAW = $clog2(W_DEPTH);
    localparam int AAW = $clog2(A_DEPTH);
    localparam int SAW = $clog2(S_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

`ifdef PE_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                         input logic signed [ACC_W-1:0] b);
`ifdef PE_SAT_EN
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        if (s[ACC_W] != s[ACC_W-1]) begin
            acc_add = s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_add = s[ACC_W-1:0];
        end
`else
        acc_add = a + b;
`endif
    endfunction

    state_t r_state, w_state_next;

    logic signed [DATA_W-1:0] r_w_spad [W_DEPTH];
    logic signed [DATA_W-1:0] r_a_spad [A_DEPTH];
    logic signed [ACC_W-1:0]  r_s_spad [S_DEPTH];
    logic [WAW:0]             r_wptr;
    logic [AAW:0]             r_aptr;

    logic [7:0]               r_k, r_kc, r_pc, r_plast, r_wbase, r_abase, r_sidx, r_didx, r_np;
    logic [3:0]               r_s;
    logic [FW-1:0]            r_f, r_fc;
    logic signed [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]         r_psum;
    logic                     r_psum_valid, r_busy, r_done, r_drain_done, r_cfg_err;

    logic [15:0] w_k16, w_n16, w_s16, w_f16, w_div, w_diff, w_p, w_fk, w_fp;
    logic        w_cfg_ok, w_start_ok, w_start_bad, w_drain_go, w_drain_empty;
    logic        w_k_last, w_f_last, w_comp_last, w_capture, w_drain_last;
    logic [7:0]  w_widx, w_aidx;
    logic signed [DATA_W-1:0]   w_wval, w_aval;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext, w_acc_next, w_sval, w_sum;

    // Configuration legality and derived output count P = floor((N-K)/S)+1
    always_comb begin
        w_k16 = {8'd0, cfg_wcount};
        w_n16 = {8'd0, cfg_acount};
        w_s16 = {12'd0, cfg_stride};
        w_f16 = 16'(cfg_nfilt);
        w_div = (cfg_stride == 4'd0) ? 16'd1 : w_s16;
        if (w_n16 >= w_k16) begin
            w_diff = w_n16 - w_k16;
        end else begin
            w_diff = 16'd0;
        end
        w_p  = (w_diff / w_div) + 16'd1;
        w_fk = w_f16 * w_k16;
        w_fp = w_f16 * w_p;
        w_cfg_ok = (w_k16 >= 16'd1) && (w_f16 >= 16'd1) && (w_f16 <= 16'(MAX_FILT)) &&
                   (w_fk <= 16'(W_DEPTH)) && (w_s16 >= 16'd1) && (w_k16 <= w_n16) &&
                   (w_n16 <= 16'(A_DEPTH)) && (w_fp <= 16'(S_DEPTH));
    end

    // Spad reads and MAC / drain-add datapath; out-of-range reads return zero
    always_comb begin
        w_widx = r_wbase + r_kc;
        w_aidx = r_abase + r_kc;
        if ({8'd0, w_widx} < 16'(W_DEPTH)) begin
            w_wval = r_w_spad[w_widx[WAW-1:0]];
        end else begin
            w_wval = {DATA_W{1'b0}};
        end
        if ({8'd0, w_aidx} < 16'(A_DEPTH)) begin
            w_aval = r_a_spad[w_aidx[AAW-1:0]];
        end else begin
            w_aval = {DATA_W{1'b0}};
        end
        if ({8'd0, r_didx} < 16'(S_DEPTH)) begin
            w_sval = r_s_spad[r_didx[SAW-1:0]];
        end else begin
            w_sval = {ACC_W{1'b0}};
        end
        w_prod     = (2*DATA_W)'(w_wval) * (2*DATA_W)'(w_aval);
        w_prod_ext = ACC_W'(w_prod);
        if (r_kc == 8'd0) begin
            w_acc_next = w_prod_ext;
        end else begin
            w_acc_next = acc_add(r_acc, w_prod_ext);
        end
        w_sum = acc_add(w_sval, $signed(psum_i));
    end

    assign psum_ready_o = (r_state == ST_DRAIN) && (!r_psum_valid || psum_ready_i);

    // Next-state and loop-end decode
    always_comb begin
        w_state_next  = r_state;
        w_start_ok    = 1'b0;
        w_start_bad   = 1'b0;
        w_drain_go    = 1'b0;
        w_drain_empty = 1'b0;
        w_k_last      = (r_kc == r_k - 8'd1);
        w_f_last      = (r_fc == r_f - FW'(1));
        w_comp_last   = 1'b0;
        w_capture     = 1'b0;
        w_drain_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start_ok   = w_cfg_ok;
                    w_start_bad  = !w_cfg_ok;
                    w_state_next = w_cfg_ok ? ST_COMPUTE : ST_IDLE;
                end else if (drain_i) begin
                    w_drain_go    = 1'b1;
                    w_drain_empty = (r_np == 8'd0);
                    w_state_next  = (r_np == 8'd0) ? ST_IDLE : ST_DRAIN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                w_comp_last = w_k_last && w_f_last && (r_pc == r_plast);
                if (w_comp_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_COMPUTE;
                end
            end
            ST_DRAIN: begin
                w_capture    = psum_valid_i && psum_ready_o;
                w_drain_last = w_capture && (r_didx == r_np - 8'd1);
                if (w_drain_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Loop counters, latched configuration, drain handshake and status pulses
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_k <= 8'd0; r_kc <= 8'd0; r_pc <= 8'd0; r_plast <= 8'd0;
            r_wbase <= 8'd0; r_abase <= 8'd0; r_sidx <= 8'd0; r_didx <= 8'd0; r_np <= 8'd0;
            r_s <= 4'd0; r_f <= {FW{1'b0}}; r_fc <= {FW{1'b0}};
            r_acc <= {ACC_W{1'b0}}; r_psum <= {ACC_W{1'b0}};
            r_psum_valid <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
            r_drain_done <= 1'b0; r_cfg_err <= 1'b0;
        end else begin
            r_busy       <= (w_state_next != ST_IDLE);
            r_done       <= w_comp_last;
            r_cfg_err    <= w_start_bad;
            r_drain_done <= w_drain_last || w_drain_empty;
            if (w_start_ok) begin
                r_k <= cfg_wcount; r_s <= cfg_stride; r_f <= cfg_nfilt;
                r_plast <= 8'(w_p - 16'd1);
                r_np <= 8'(w_fp);
                r_kc <= 8'd0; r_pc <= 8'd0; r_fc <= {FW{1'b0}};
                r_wbase <= 8'd0; r_abase <= 8'd0; r_sidx <= 8'd0;
            end
            if (r_state == ST_COMPUTE) begin
                r_acc <= w_acc_next;
                if (w_k_last) begin
                    r_kc   <= 8'd0;
                    r_sidx <= r_sidx + 8'd1;
                    if (w_f_last) begin
                        r_fc    <= {FW{1'b0}};
                        r_wbase <= 8'd0;
                        r_pc    <= r_pc + 8'd1;
                        r_abase <= r_abase + {4'd0, r_s};
                    end else begin
                        r_fc    <= r_fc + FW'(1);
                        r_wbase <= r_wbase + r_k;
                    end
                end else begin
                    r_kc <= r_kc + 8'd1;
                end
            end
            if (w_drain_go) begin
                r_didx <= 8'd0;
            end
            // A pending output survives the return to IDLE until the consumer takes it
            if (w_capture) begin
                r_psum       <= w_sum;
                r_psum_valid <= 1'b1;
                r_didx       <= r_didx + 8'd1;
            end else if (r_psum_valid && psum_ready_i) begin
                r_psum_valid <= 1'b0;
            end
        end
    end

    // Scratchpads: IDLE-time loads, psum write-back from compute and drain
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < W_DEPTH; i++) r_w_spad[i] <= {DATA_W{1'b0}};
            for (int i = 0; i < A_DEPTH; i++) r_a_spad[i] <= {DATA_W{1'b0}};
            for (int i = 0; i < S_DEPTH; i++) r_s_spad[i] <= {ACC_W{1'b0}};
            r_wptr <= {(WAW+1){1'b0}};
            r_aptr <= {(AAW+1){1'b0}};
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_valid_i) begin
                    if (r_wptr < (WAW+1)'(W_DEPTH)) begin
                        r_w_spad[r_wptr[WAW-1:0]] <= w_data_i;
                        r_wptr <= r_wptr + (WAW+1)'(1);
                    end
                end else begin
                    r_wptr <= {(WAW+1){1'b0}};
                end
                if (a_valid_i) begin
                    if (r_aptr < (AAW+1)'(A_DEPTH)) begin
                        r_a_spad[r_aptr[AAW-1:0]] <= a_data_i;
                        r_aptr <= r_aptr + (AAW+1)'(1);
                    end
                end else begin
                    r_aptr <= {(AAW+1){1'b0}};
                end
            end
            if ((r_state == ST_COMPUTE) && w_k_last && ({8'd0, r_sidx} < 16'(S_DEPTH))) begin
                r_s_spad[r_sidx[SAW-1:0]] <= w_acc_next;
            end
            if (w_capture && ({8'd0, r_didx} < 16'(S_DEPTH))) begin
                r_s_spad[r_didx[SAW-1:0]] <= w_sum;
            end
        end
    end

    assign psum_o       = r_psum;
    assign psum_valid_o = r_psum_valid;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign drain_done_o = r_drain_done;
    assign cfg_err_o    = r_cfg_err;

endmodule

// File: tb/tb_pe_strided_multifilter.sv
// Directed self-checking bench for pe_strided_multifilter: compute, stride/multifilter,
// drain with backpressure, overflow, config error and mid-run reset.
module tb_pe_strided_multifilter;
    localparam int ACC_W = 20;

    logic              clk = 1'b0;
    logic              nrst;
    logic [7:0]        cfg_wcount, cfg_acount;
    logic [3:0]        cfg_stride;
    logic [2:0]        cfg_nfilt;
    logic              w_valid_i, a_valid_i, start_i, drain_i;
    logic [7:0]        w_data_i, a_data_i;
    logic [ACC_W-1:0]  psum_i, psum_o;
    logic              psum_valid_i, psum_ready_o, psum_valid_o, psum_ready_i;
    logic              busy_o, done_o, drain_done_o, cfg_err_o;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]       wv [16];
    logic [7:0]       av [16];
    logic [ACC_W-1:0] exp_v [6];
    logic [ACC_W-1:0] got_q [$];

    always #5 clk = ~clk;

    pe_strided_multifilter dut (
        .clk(clk), .nrst(nrst),
        .cfg_wcount(cfg_wcount), .cfg_acount(cfg_acount), .cfg_stride(cfg_stride), .cfg_nfilt(cfg_nfilt),
        .w_valid_i(w_valid_i), .w_data_i(w_data_i), .a_valid_i(a_valid_i), .a_data_i(a_data_i),
        .start_i(start_i), .drain_i(drain_i),
        .psum_i(psum_i), .psum_valid_i(psum_valid_i), .psum_ready_o(psum_ready_o),
        .psum_o(psum_o), .psum_valid_o(psum_valid_o), .psum_ready_i(psum_ready_i),
        .busy_o(busy_o), .done_o(done_o), .drain_done_o(drain_done_o), .cfg_err_o(cfg_err_o)
    );

    function automatic logic [ACC_W-1:0] v20(input int x);
        return x[ACC_W-1:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int k, input int n, input int s, input int f);
        cfg_wcount = k[7:0];
        cfg_acount = n[7:0];
        cfg_stride = s[3:0];
        cfg_nfilt  = f[2:0];
    endtask

    task automatic set_basic;
        set_cfg(3, 5, 1, 1);
        for (int i = 0; i < 16; i++) begin
            wv[i] = 8'd0;
            av[i] = 8'd0;
        end
        wv[0] = 8'd1; wv[1] = 8'd2; wv[2] = 8'd3;
        for (int i = 0; i < 5; i++) av[i] = 8'(i + 1);
    endtask

    task automatic load(input int nw, input int na);
        int m;
        m = (nw > na) ? nw : na;
        for (int i = 0; i < m; i++) begin
            w_valid_i = (i < nw);
            w_data_i  = wv[i];
            a_valid_i = (i < na);
            a_data_i  = av[i];
            tick;
        end
        w_valid_i = 1'b0;
        a_valid_i = 1'b0;
        tick;
    endtask

    task automatic run_compute(output int ncyc, output int nbusy);
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        ncyc  = 0;
        nbusy = busy_o ? 1 : 0;
        while (done_o !== 1'b1 && ncyc < 300) begin
            tick;
            ncyc++;
            if (busy_o) nbusy++;
        end
    endtask

    task automatic do_drain(input logic [ACC_W-1:0] pin, input logic [4:0] pat, input int nexp,
                            output int ndone, output int nhold_bad);
        int c;
        logic prev_hold;
        logic [ACC_W-1:0] prev_val;
        got_q.delete();
        ndone = 0;
        nhold_bad = 0;
        drain_i = 1'b1;
        tick;
        drain_i = 1'b0;
        if (drain_done_o) ndone++;
        psum_valid_i = 1'b1;
        psum_i = pin;
        c = 0;
        prev_hold = 1'b0;
        prev_val = '0;
        while (got_q.size() < nexp && c < 200) begin
            psum_ready_i = (c < 5) ? pat[c] : 1'b1;
            if (prev_hold && psum_o !== prev_val) nhold_bad++;
            if (psum_valid_o && psum_ready_i) got_q.push_back(psum_o);
            prev_hold = psum_valid_o && !psum_ready_i;
            prev_val  = psum_o;
            tick;
            c++;
            if (drain_done_o) ndone++;
        end
        psum_valid_i = 1'b0;
        psum_ready_i = 1'b0;
        tick;
        if (drain_done_o) ndone++;
    endtask

    task automatic test_reset;
        int nd, nh;
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy_o, done_o, psum_valid_o, drain_done_o, cfg_err_o, psum_ready_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy_o, done_o, psum_valid_o, drain_done_o, cfg_err_o, psum_ready_o});
        end
        n_vec++;
        if (psum_o !== '0) begin
            n_err++;
            $display("FAIL reset_psum: got %0d expected 0", psum_o);
        end
        @(negedge clk);
        nrst = 1'b1;
        tick;
        do_drain('0, 5'b11111, 0, nd, nh);
        n_vec++;
        if (nd != 1 || got_q.size() != 0) begin
            n_err++;
            $display("FAIL empty_drain: got done=%0d outputs=%0d expected done=1 outputs=0", nd, got_q.size());
        end
    endtask

    task automatic test_basic;
        int nc, nb;
        set_basic;
        load(3, 5);
        run_compute(nc, nb);
        n_vec++;
        if (nc != 9) begin
            n_err++;
            $display("FAIL basic_latency: got %0d expected 9", nc);
        end
        n_vec++;
        if (nb != 9) begin
            n_err++;
            $display("FAIL basic_busy_cycles: got %0d expected 9", nb);
        end
        tick;
        n_vec++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_cfg_err;
        int nd, nh;
        set_cfg(4, 3, 1, 1);
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        n_vec++;
        if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_err_pulse: got err=%b busy=%b expected 1 0", cfg_err_o, busy_o);
        end
        tick;
        n_vec++;
        if (cfg_err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_err_clear: got err=%b busy=%b expected 0 0", cfg_err_o, busy_o);
        end
        set_basic;
        exp_v[0] = v20(14); exp_v[1] = v20(20); exp_v[2] = v20(26);
        do_drain('0, 5'b11111, 3, nd, nh);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= got_q.size() || got_q[i] !== exp_v[i]) begin
                n_err++;
                $display("FAIL cfg_err_spad[%0d]: got %0d expected %0d", i,
                         (i < got_q.size()) ? $signed(got_q[i]) : 0, $signed(exp_v[i]));
            end
        end
    endtask

    task automatic test_drain_backpressure;
        int nd, nh;
        exp_v[0] = v20(114); exp_v[1] = v20(120); exp_v[2] = v20(126);
        do_drain(v20(100), 5'b11001, 3, nd, nh);
        n_vec++;
        if (got_q.size() != 3) begin
            n_err++;
            $display("FAIL bp_count: got %0d expected 3", got_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= got_q.size() || got_q[i] !== exp_v[i]) begin
                n_err++;
                $display("FAIL bp_value[%0d]: got %0d expected %0d", i,
                         (i < got_q.size()) ? $signed(got_q[i]) : 0, $signed(exp_v[i]));
            end
        end
        n_vec++;
        if (nh != 0) begin
            n_err++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", nh);
        end
        n_vec++;
        if (nd != 1) begin
            n_err++;
            $display("FAIL bp_drain_done: got %0d pulses expected 1", nd);
        end
        n_vec++;
        if (psum_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: got valid=%b busy=%b expected 0 0", psum_valid_o, busy_o);
        end
    endtask

    task automatic test_overflow;
        int nc, nb, nd, nh;
        set_basic;
        run_compute(nc, nb);
        n_vec++;
        if (nc != 9) begin
            n_err++;
            $display("FAIL ovf_latency: got %0d expected 9", nc);
        end
`ifdef PE_SAT_EN
        exp_v[0] = v20(524287); exp_v[1] = v20(524287); exp_v[2] = v20(524287);
`else
        exp_v[0] = v20(-524275); exp_v[1] = v20(-524269); exp_v[2] = v20(-524263);
`endif
        do_drain(v20(524287), 5'b11111, 3, nd, nh);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= got_q.size() || got_q[i] !== exp_v[i]) begin
                n_err++;
                $display("FAIL ovf_value[%0d]: got %0d expected %0d", i,
                         (i < got_q.size()) ? $signed(got_q[i]) : 0, $signed(exp_v[i]));
            end
        end
    endtask

    task automatic test_stride_multifilter;
        int nc, nb, nd, nh;
        set_cfg(2, 6, 2, 2);
        wv[0] = 8'd1; wv[1] = 8'd1; wv[2] = 8'd1; wv[3] = 8'hFF;
        for (int i = 0; i < 6; i++) av[i] = 8'(i + 1);
        load(4, 6);
        run_compute(nc, nb);
        n_vec++;
        if (nc != 12) begin
            n_err++;
            $display("FAIL stride_latency: got %0d expected 12", nc);
        end
        exp_v[0] = v20(3); exp_v[1] = v20(-1); exp_v[2] = v20(7);
        exp_v[3] = v20(-1); exp_v[4] = v20(11); exp_v[5] = v20(-1);
        do_drain('0, 5'b11111, 6, nd, nh);
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (i >= got_q.size() || got_q[i] !== exp_v[i]) begin
                n_err++;
                $display("FAIL stride_sum[%0d]: got %0d expected %0d", i,
                         (i < got_q.size()) ? $signed(got_q[i]) : 0, $signed(exp_v[i]));
            end
        end
    endtask

    task automatic test_reset_midrun;
        int nc, nb, nd, nh;
        set_basic;
        load(3, 5);
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        repeat (4) tick;
        nrst = 1'b0;
        #1;
        n_vec++;
        if ({busy_o, done_o, psum_valid_o, drain_done_o, cfg_err_o, psum_ready_o} !== 6'b0 || psum_o !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: got flags=%b psum=%0d expected 000000 0",
                     {busy_o, done_o, psum_valid_o, drain_done_o, cfg_err_o, psum_ready_o}, psum_o);
        end
        @(negedge clk);
        nrst = 1'b1;
        tick;
        n_vec++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_idle: got busy=%b done=%b expected 0 0", busy_o, done_o);
        end
        load(3, 5);
        run_compute(nc, nb);
        n_vec++;
        if (nc != 9) begin
            n_err++;
            $display("FAIL midrun_latency: got %0d expected 9", nc);
        end
        exp_v[0] = v20(14); exp_v[1] = v20(20); exp_v[2] = v20(26);
        do_drain('0, 5'b11111, 3, nd, nh);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= got_q.size() || got_q[i] !== exp_v[i]) begin
                n_err++;
                $display("FAIL midrun_sum[%0d]: got %0d expected %0d", i,
                         (i < got_q.size()) ? $signed(got_q[i]) : 0, $signed(exp_v[i]));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0;
        set_cfg(0, 0, 0, 0);
        w_valid_i = 1'b0; w_data_i = 8'd0;
        a_valid_i = 1'b0; a_data_i = 8'd0;
        start_i = 1'b0; drain_i = 1'b0;
        psum_i = '0; psum_valid_i = 1'b0; psum_ready_i = 1'b0;
        test_reset;
        test_basic;
        test_cfg_err;
        test_drain_backpressure;
        test_overflow;
        test_stride_multifilter;
        test_reset_midrun;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
